// File: rtl/alu_mul_ctrl.sv
// Shift-add multiplier controller that borrows a shared datapath ALU for its adds.
// Outside RUN the ALU ports simply forward the datapath's own pass_* operands.
module alu_mul_ctrl #(
  parameter int ITER_MAX = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  input  logic [3:0]  pass_ctl,
  input  logic [31:0] pass_a,
  input  logic [31:0] pass_b,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [5:0] CNT_LAST = 6'(ITER_MAX - 1);

  state_t      state, nxt;
  logic [31:0] acc, mcand, mplier;
  logic [5:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Early exit once no multiplier bits remain, so RUN length tracks op_b's msb.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (op_b == 32'd0) ? DONE : RUN;
      RUN:     if (mplier[31:1] == 31'd0 || cnt == CNT_LAST) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ready   = (state == IDLE);
    busy    = (state == RUN);
    done    = (state == DONE);
    alu_ctl = pass_ctl;
    alu_a   = pass_a;
    alu_b   = pass_b;
    if (state == RUN) begin
      alu_ctl = 4'd0;
      alu_a   = acc;
      alu_b   = mcand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (state == IDLE && start) begin
      acc    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
      cnt    <= '0;
    end else if (state == RUN) begin
      if (mplier[0]) acc <= alu_out;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 6'd1;
    end
  end

  assign result = acc;

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Directed bench for alu_mul_ctrl: stimulus queues expected products, a monitor
// checks result on each done pulse; the bench also models the shared ALU.
module tb_alu_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        ready, busy, done;
  logic [31:0] result;
  logic [3:0]  pass_ctl = 4'd1;
  logic [31:0] pass_a = 32'd10, pass_b = 32'd3;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_out;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  alu_mul_ctrl #(.ITER_MAX(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .pass_ctl(pass_ctl), .pass_a(pass_a), .pass_b(pass_b),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  always_comb begin
    alu_out = '0;
    case (alu_ctl)
      4'd0: alu_out = alu_a + alu_b;
      4'd1: alu_out = alu_a - alu_b;
      4'd2: alu_out = alu_a & alu_b;
      4'd3: alu_out = alu_a | alu_b;
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding product.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else chk("result", result, sb.pop_front());
    end
  end

  // Issue one multiply; lat = cycles from accepting edge to done, runs = busy cycles.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input int runs, input bit poke);
    int n, nb;
    @(negedge clk);
    chk("ready_before", 32'(ready), 32'd1);
    op_a = a; op_b = b; start = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    n = 1; nb = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) begin
        nb++;
        if (nb == 1) chk("run_alu_ctl", 32'(alu_ctl), 32'd0);
      end
      start = (poke && n == 2);
      op_a = 32'hDEAD; op_b = 32'hBEEF;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_latency", 32'(n), 32'(lat));
    chk("busy_cycles", 32'(nb), 32'(runs));
    @(negedge clk);
    chk("ready_after", 32'(ready), 32'd1);
    chk("result_held", result, exp);
  endtask

  initial begin
    #2;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_a", alu_a, 32'd10);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_alu_ctl", 32'(alu_ctl), 32'd1);
    chk("idle_alu_a", alu_a, 32'd10);
    chk("idle_alu_b", alu_b, 32'd3);

    do_mul(32'd3, 32'd5, 32'd15, 4, 3, 1'b0);
    do_mul(32'h1234, 32'd0, 32'd0, 1, 0, 1'b0);
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 32, 1'b0);
    do_mul(32'd7, 32'd6, 32'd42, 4, 3, 1'b1);
    do_mul(32'd123, 32'd456, 32'd56088, 10, 9, 1'b0);
    do_mul(32'h00010000, 32'h00010000, 32'd0, 18, 17, 1'b0);
    do_mul(32'h80000000, 32'd2, 32'd0, 3, 2, 1'b0);

    // Abort 9*0xFF on its second RUN cycle.
    @(negedge clk);
    op_a = 32'd9; op_b = 32'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("abort_busy2", 32'(busy), 32'd1);
    pass_ctl = 4'd3; pass_a = 32'h55; pass_b = 32'hAA;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_result", result, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_alu_ctl", 32'(alu_ctl), 32'd3);
    chk("abort_alu_b", alu_b, 32'hAA);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pass_ctl = 4'd1; pass_a = 32'd10; pass_b = 32'd3;
    repeat (10) @(negedge clk);
    do_mul(32'd2, 32'd3, 32'd6, 3, 2, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_ctrl.md
ALU_MUL_CTRL -- requirements
Module: alu_mul_ctrl

Interface
REQ-001 SHALL have parameter ITER_MAX, default 32, the maximum number of shift-add iterations (equals data width).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  multiply request; sampled only while ready=1.
REQ-005 SHALL have port op_a  input  32  multiplicand, captured on the accepting edge.
REQ-006 SHALL have port op_b  input  32  multiplier, captured on the accepting edge.
REQ-007 SHALL have port ready  output  1  high in IDLE only.
REQ-008 SHALL have port busy  output  1  high in RUN only.
REQ-009 SHALL have port done  output  1  single-cycle pulse, high in DONE only.
REQ-010 SHALL have port result  output  32  low 32 bits of op_a*op_b (unsigned), held until the next accepted start.
REQ-011 SHALL have port pass_ctl  input  4  datapath ALU control, forwarded when not busy.
REQ-012 SHALL have ports pass_a, pass_b  input  32 each  datapath ALU operands, forwarded when not busy.
REQ-013 SHALL have port alu_ctl  output  4  to shared ALU ctl (4'd0 add, 4'd1 sub, 4'd2 and, 4'd3 or).
REQ-014 SHALL have ports alu_a, alu_b  output  32 each  to shared ALU operands.
REQ-015 SHALL have port alu_out  input  32  shared ALU result, combinational from alu_ctl/alu_a/alu_b.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE, with internal registers acc[31:0], mcand[31:0], mplier[31:0], cnt[5:0].
REQ-017 SHALL, in IDLE with start=1: load acc=0, mcand=op_a, mplier=op_b, cnt=0; go to RUN if op_b!=0, else go to DONE.
REQ-018 SHALL, in IDLE with start=0: remain in IDLE; registers unchanged.
REQ-019 SHALL, each RUN cycle: drive alu_ctl=4'd0, alu_a=acc, alu_b=mcand; at the edge, acc<=alu_out if mplier[0]=1, else acc is held; mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
REQ-020 SHALL leave RUN for DONE at the edge where the shifted mplier is 0 or cnt reaches ITER_MAX-1 (early termination).
REQ-021 SHALL produce RUN length = 1 + index of the most-significant set bit of op_b, so done rises (msb+2) cycles after the accepting edge; op_b=0 gives done one cycle after acceptance.
REQ-022 SHALL discard ALU addition carry (mod 2^32 arithmetic); mcand bits shifted past bit 31 are lost.
REQ-023 SHALL, in DONE: assert done=1 for exactly one cycle, with result=acc valid; go to IDLE on the next edge unconditionally.
REQ-024 SHALL drive result from acc; result is stable from the DONE cycle until the next accepted start.
REQ-025 SHALL ignore start in RUN and DONE (no restart, no queueing).
REQ-026 SHALL, in IDLE and DONE, drive alu_ctl=pass_ctl, alu_a=pass_a, alu_b=pass_b combinationally; in RUN, ignore pass_* entirely.
REQ-027 SHALL decode ready, busy and done from state only (registered, glitch-free relative to inputs).

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force state=IDLE, acc=mcand=mplier=0, cnt=0; hence ready=1, busy=0, done=0, result=0.
REQ-029 SHALL, on reset asserted mid-RUN, abort the operation with no done pulse; the first start after rst_n deasserts begins a fresh operation.
REQ-030 SHALL, with alu_ctl/alu_a/alu_b in reset, follow pass_* (state IDLE).

Verification
REQ-031 SHALL check op_a=3, op_b=5 -> 3 RUN cycles (busy=1), done pulse on the 4th cycle after acceptance, result=15.
REQ-032 SHALL check op_a=0x1234, op_b=0 -> no RUN cycle, done on the cycle after acceptance, result=0.
REQ-033 SHALL check op_a=op_b=0xFFFFFFFF -> 32 RUN cycles, done on the 33rd cycle, result=0x00000001.
REQ-034 SHALL check IDLE with pass_ctl=4'd1, pass_a=10, pass_b=3 -> alu_ctl=1, alu_a=10, alu_b=3; during RUN, alu_ctl=0 regardless of pass_*.
REQ-035 SHALL check start pulsed during RUN of 7*6 -> ignored, result=42, exactly one done pulse.
REQ-036 SHALL check rst_n=0 on the 2nd RUN cycle of 9*0xFF -> immediate ready=1, result=0, no done; subsequent 2*3 -> result=6.
